// File: rtl/iterative_alu.sv
// iterative_alu: execute-stage ALU with a start/done handshake.
//   Logic, add/sub, shift and signed compare finish in one cycle. Multiply
//   (low/high) and unsigned divide/remainder take WIDTH iterations, one bit
//   per cycle, using shift-add multiply and restoring division.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start              request, accepted only while busy=0
//   alu_op[3:0]        operation code from the decode stage
//   a, b [WIDTH-1:0]   operands, sampled on acceptance only
//   busy               iterative op in flight, further starts are dropped
//   done               one-cycle pulse, result/zero/invalid_op updated
//   result [WIDTH-1:0] registered result, held until the next done
//   zero               result == 0, registered with result
//   invalid_op         last completed op code was unsupported
module iterative_alu #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             invalid_op
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_MULL = 4'b1000;
  localparam logic [3:0] OP_MULH = 4'b1001;
  localparam logic [3:0] OP_DIVU = 4'b1010;
  localparam logic [3:0] OP_REMU = 4'b1011;

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  logic [1:0]         r_state;
  logic [3:0]         r_op;
  logic [SHW-1:0]     r_cnt;
  logic [2*WIDTH-1:0] r_acc;    // {partial product high, remaining multiplier}
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH:0]     r_rem;    // partial remainder with next dividend bit appended
  logic [WIDTH-1:0]   r_quo;    // remaining dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0]   r_dvsr;
  logic               r_done;
  logic [WIDTH-1:0]   r_result;
  logic               r_zero;
  logic               r_inv;

  logic               w_accept;
  logic [WIDTH-1:0]   w_sc_res;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_acc_nxt;
  logic [WIDTH:0]     w_trial;
  logic               w_qbit;
  logic [WIDTH-1:0]   w_rem_nxt;
  logic [WIDTH-1:0]   w_quo_nxt;
  logic               w_last;
  logic [WIDTH-1:0]   w_it_res;

  assign w_accept = start && (r_state == S_IDLE);
  assign w_last   = (r_cnt == CNT_LAST);

  // Single-cycle datapath, evaluated straight off the input operands.
  always_comb begin
    w_sc_res = '0;
    case (alu_op)
      OP_ADD: w_sc_res = a + b;
      OP_SUB: w_sc_res = a - b;
      OP_AND: w_sc_res = a & b;
      OP_OR:  w_sc_res = a | b;
      OP_XOR: w_sc_res = a ^ b;
      OP_SLL: w_sc_res = a << b[SHW-1:0];
      OP_SRL: w_sc_res = a >> b[SHW-1:0];
      OP_SLT: w_sc_res = ($signed(a) < $signed(b)) ? WIDTH'(1) : '0;
      default: w_sc_res = '0;
    endcase
  end

  // Shift-add step: add multiplicand into the high half when the current
  // multiplier LSB is set, then shift the whole accumulator right by one.
  assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                   + (r_acc[0] ? {1'b0, r_mcand} : '0);
  assign w_acc_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Restoring division step. A zero divisor always passes the trial subtract,
  // which naturally yields an all-ones quotient and a remainder equal to a.
  assign w_trial   = r_rem - {1'b0, r_dvsr};
  assign w_qbit    = ~w_trial[WIDTH];
  assign w_rem_nxt = w_qbit ? w_trial[WIDTH-1:0] : r_rem[WIDTH-1:0];
  assign w_quo_nxt = {r_quo[WIDTH-2:0], w_qbit};

  always_comb begin
    w_it_res = '0;
    case (r_op)
      OP_MULL: w_it_res = w_acc_nxt[WIDTH-1:0];
      OP_MULH: w_it_res = w_acc_nxt[2*WIDTH-1:WIDTH];
      OP_DIVU: w_it_res = w_quo_nxt;
      OP_REMU: w_it_res = w_rem_nxt;
      default: w_it_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvsr   <= '0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_zero   <= 1'b1;
      r_inv    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_op <= alu_op;
        if (!alu_op[3]) begin
          r_done   <= 1'b1;
          r_result <= w_sc_res;
          r_zero   <= (w_sc_res == '0);
          r_inv    <= 1'b0;
        end else if (alu_op[2]) begin
          r_done   <= 1'b1;
          r_result <= '0;
          r_zero   <= 1'b1;
          r_inv    <= 1'b1;
        end else if (!alu_op[1]) begin
          r_state <= S_MUL;
          r_cnt   <= '0;
          r_mcand <= a;
          r_acc   <= {{WIDTH{1'b0}}, b};
        end else begin
          r_state <= S_DIV;
          r_cnt   <= '0;
          r_dvsr  <= b;
          r_rem   <= {{WIDTH{1'b0}}, a[WIDTH-1]};
          r_quo   <= {a[WIDTH-2:0], 1'b0};
        end
      end else if (r_state != S_IDLE) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_state == S_MUL) begin
          r_acc <= w_acc_nxt;
        end else begin
          r_rem <= {w_rem_nxt, r_quo[WIDTH-1]};
          r_quo <= w_quo_nxt;
        end
        if (w_last) begin
          r_state  <= S_IDLE;
          r_cnt    <= '0;
          r_done   <= 1'b1;
          r_result <= w_it_res;
          r_zero   <= (w_it_res == '0);
          r_inv    <= 1'b0;
        end
      end
    end
  end

  assign busy       = (r_state != S_IDLE);
  assign done       = r_done;
  assign result     = r_result;
  assign zero       = r_zero;
  assign invalid_op = r_inv;

endmodule
